// File: rtl/avalon_displays7seg_pkg.sv
// -----------------------------------------------------------------------------
// avalon_displays7seg_pkg
// Shared definitions for the 7-segment display writer (Avalon-MM master).
//   state_t            : writer FSM states
//   NUM_DIGITS_DEFAULT : number of display digits
//   DIGIT_STRIDE       : byte stride between digit registers in the slave
//   BYTEENABLE_DIGIT   : byte enable used for every digit write
//   digit_addr()       : byte address of a digit register
// -----------------------------------------------------------------------------
package avalon_displays7seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int NUM_DIGITS_DEFAULT = 8;
  localparam int DIGIT_STRIDE       = 4;

  localparam logic [3:0] BYTEENABLE_DIGIT = 4'b0001;

  // Digit i lives at base + DIGIT_STRIDE*i.
  function automatic logic [31:0] digit_addr(input logic [31:0] base,
                                             input logic [31:0] idx);
    return base + (idx * 32'(DIGIT_STRIDE));
  endfunction

endpackage

// File: rtl/avalon_displays7seg_shadow.sv
// -----------------------------------------------------------------------------
// avalon_displays7seg_shadow
// Shadow copy of the nibble last written to each display digit, plus a valid
// bit per digit. Produces the dirty flag for the digit currently being scanned.
//   clk, reset : clock, asynchronous active-high reset (invalidates all digits)
//   i_idx      : digit index under inspection / being updated
//   i_nibble   : requested nibble for digit i_idx
//   i_mask     : captured per-digit update mask
//   i_wr_en    : write-update strobe; stores i_nibble at i_idx and marks valid
//   o_dirty    : digit i_idx is enabled and differs from (or lacks) its shadow
// -----------------------------------------------------------------------------
module avalon_displays7seg_shadow
  import avalon_displays7seg_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT,
  parameter int IDX_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [3:0]            i_nibble,
  input  logic [NUM_DIGITS-1:0] i_mask,
  input  logic                  i_wr_en,
  output logic                  o_dirty
);

  logic [NUM_DIGITS-1:0] w_dirty_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] r_nibble;
      logic       r_valid;
      logic       w_sel;

      assign w_sel = (i_idx == IDX_W'(gi));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_nibble <= 4'h0;
          r_valid  <= 1'b0;
        end else if (i_wr_en && w_sel) begin
          r_nibble <= i_nibble;
          r_valid  <= 1'b1;
        end
      end

      // Only the selected digit can contribute, so the OR below acts as a mux.
      assign w_dirty_vec[gi] = w_sel & i_mask[gi] &
                               (~r_valid | (r_nibble != i_nibble));
    end
  endgenerate

  assign o_dirty = |w_dirty_vec;

endmodule

// File: rtl/avalon_displays7seg_writer.sv
// -----------------------------------------------------------------------------
// avalon_displays7seg_writer
// Avalon-MM master feeding the 8-digit 7-segment display slave. A request
// (32-bit hex value + per-digit mask) is scanned digit by digit; every enabled
// digit whose value differs from the shadow copy gets one single-word write.
//   clk, reset         : clock, asynchronous active-high reset
//   in_valid/in_ready  : request handshake (accepted only in IDLE)
//   in_data            : hex value, digit i = in_data[4i+3:4i]
//   in_mask            : bit i enables updates of digit i
//   avm_*              : Avalon-MM write master (registered outputs)
//   busy               : request in progress
//   done               : one-cycle pulse when a request completes
// -----------------------------------------------------------------------------
module avalon_displays7seg_writer
  import avalon_displays7seg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          NUM_DIGITS = NUM_DIGITS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_data,
  input  logic [NUM_DIGITS-1:0]   in_mask,
  output logic [31:0]             avm_address,
  output logic                    avm_write,
  output logic [31:0]             avm_writedata,
  output logic [3:0]              avm_byteenable,
  input  logic                    avm_waitrequest,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_data;
  logic [NUM_DIGITS-1:0]   r_mask;
  logic                    r_in_ready;
  logic                    r_avm_write;
  logic [31:0]             r_avm_address;
  logic [31:0]             r_avm_writedata;
  logic [3:0]              r_avm_byteenable;
  logic                    r_busy;
  logic                    r_done;

  logic [3:0]              w_nibble;
  logic                    w_dirty;
  logic                    w_write_done;
  logic                    w_last;

  assign w_nibble     = r_data[{r_idx, 2'b00} +: 4];
  assign w_last       = (r_idx == LAST_IDX);
  // The slave accepts the write on the first edge without waitrequest.
  assign w_write_done = (r_state == ST_WRITE) && !avm_waitrequest;

  avalon_displays7seg_shadow #(
    .NUM_DIGITS (NUM_DIGITS),
    .IDX_W      (IDX_W)
  ) u_shadow (
    .clk      (clk),
    .reset    (reset),
    .i_idx    (r_idx),
    .i_nibble (w_nibble),
    .i_mask   (r_mask),
    .i_wr_en  (w_write_done),
    .o_dirty  (w_dirty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_idx            <= '0;
      r_data           <= '0;
      r_mask           <= '0;
      r_in_ready       <= 1'b0;
      r_avm_write      <= 1'b0;
      r_avm_address    <= '0;
      r_avm_writedata  <= '0;
      r_avm_byteenable <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
          if (in_valid && r_in_ready) begin
            r_data     <= in_data;
            r_mask     <= in_mask;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (w_dirty) begin
            // Bus outputs are set up here so they are valid for the whole
            // WRITE state and stay frozen during waitrequest.
            r_avm_write      <= 1'b1;
            r_avm_address    <= digit_addr(BASE_ADDR, 32'(r_idx));
            r_avm_writedata  <= {28'b0, w_nibble};
            r_avm_byteenable <= BYTEENABLE_DIGIT;
            r_state          <= ST_WRITE;
          end else if (w_last) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        ST_WRITE: begin
          if (!avm_waitrequest) begin
            r_avm_write      <= 1'b0;
            r_avm_address    <= '0;
            r_avm_writedata  <= '0;
            r_avm_byteenable <= '0;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_SCAN;
            end
          end
        end

        ST_DONE: begin
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready       = r_in_ready;
  assign avm_write      = r_avm_write;
  assign avm_address    = r_avm_address;
  assign avm_writedata  = r_avm_writedata;
  assign avm_byteenable = r_avm_byteenable;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule

// File: tb/tb_avalon_displays7seg_writer.sv
// -----------------------------------------------------------------------------
// tb_avalon_displays7seg_writer
// Directed bench for the 7-segment display writer. A monitor logs every
// completed bus write and the done pulse, timed in edges after the accept
// edge; each test task compares the log against hand-computed values.
// -----------------------------------------------------------------------------
module tb_avalon_displays7seg_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic [7:0]  in_mask = 8'h0;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b0;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  int ecount   = 0;
  int acc_edge = 0;
  int done_rel = -1;
  int done_cnt = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_rel_q[$];

  always #5 clk = ~clk;

  avalon_displays7seg_writer #(
    .BASE_ADDR  (32'h0000_0000),
    .NUM_DIGITS (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_mask         (in_mask),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done)
  );

  // Edge-level monitor: values seen here are the ones present just before
  // the edge, i.e. what the slave samples.
  always @(posedge clk) begin
    if (in_valid && in_ready) acc_edge <= ecount;
    if (avm_write && !avm_waitrequest) begin
      wr_addr_q.push_back(avm_address);
      wr_data_q.push_back(avm_writedata);
      wr_rel_q.push_back(ecount - acc_edge);
    end
    if (done) begin
      done_rel <= ecount - acc_edge;
      done_cnt <= done_cnt + 1;
    end
    ecount <= ecount + 1;
  end

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_rel_q.delete();
    done_rel = -1;
  endtask

  // Present a request at a negedge and hold it until accepted.
  task automatic send(input logic [31:0] d, input logic [7:0] m);
    bit ok;
    ok = 0;
    in_data  = d;
    in_mask  = m;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (in_ready) ok = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_accept: in_ready never seen, data=%h required accept", d);
    end
  endtask

  task automatic wait_done(input int base);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (done_cnt > base) ok = 1;
      else @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_done: done_cnt=%0d required >%0d", done_cnt, base);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, avm_write, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: ready/write/busy/done=%b required 0000",
               {in_ready, avm_write, busy, done});
    end
    checks++;
    if ({avm_address, avm_writedata, avm_byteenable} !== 68'h0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h data=%h be=%b required 0",
               avm_address, avm_writedata, avm_byteenable);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_pre: in_ready=%b required 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_post: in_ready=%b required 1", in_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_full_write();
    int base;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    clear_log();
    base = done_cnt;
    send(32'h1234_5678, 8'hFF);
    wait_done(base);
    checks++;
    if (wr_addr_q.size() != 8) begin
      errors++;
      $display("FAIL full_count: writes=%0d required 8", wr_addr_q.size());
    end
    for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
      exp_addr = 32'(4 * i);
      exp_data = 32'(8 - i);
      checks++;
      if (wr_addr_q[i] !== exp_addr || wr_data_q[i] !== exp_data || wr_rel_q[i] != 2 + 2 * i) begin
        errors++;
        $display("FAIL full_write%0d: addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                 i, wr_addr_q[i], wr_data_q[i], wr_rel_q[i], exp_addr, exp_data, 2 + 2 * i);
      end
    end
    checks++;
    if (done_rel != 17) begin
      errors++;
      $display("FAIL full_done: done cycle=%0d required 17", done_rel);
    end
    $display("test_full_write: writes=%0d done_cycle=%0d", wr_addr_q.size(), done_rel);
  endtask

  task automatic test_no_change();
    int base;
    clear_log();
    base = done_cnt;
    send(32'h1234_5678, 8'hFF);
    wait_done(base);
    checks++;
    if (wr_addr_q.size() != 0) begin
      errors++;
      $display("FAIL nochg_count: writes=%0d required 0", wr_addr_q.size());
    end
    checks++;
    if (done_rel != 9) begin
      errors++;
      $display("FAIL nochg_done: done cycle=%0d required 9", done_rel);
    end
    $display("test_no_change: writes=%0d done_cycle=%0d", wr_addr_q.size(), done_rel);
  endtask

  task automatic test_single();
    int base;
    clear_log();
    base = done_cnt;
    send(32'h1234_5679, 8'hFF);
    wait_done(base);
    checks++;
    if (wr_addr_q.size() != 1) begin
      errors++;
      $display("FAIL single_count: writes=%0d required 1", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== 32'h9) begin
        errors++;
        $display("FAIL single_write: addr=%h data=%h required addr=0 data=9",
                 wr_addr_q[0], wr_data_q[0]);
      end
    end
    checks++;
    if (done_rel != 10) begin
      errors++;
      $display("FAIL single_done: done cycle=%0d required 10", done_rel);
    end
    $display("test_single: writes=%0d done_cycle=%0d", wr_addr_q.size(), done_rel);
  endtask

  // Only digit 2 changes (6 -> A); stall its write for 3 cycles.
  task automatic test_stall();
    int base;
    bit seen;
    logic [31:0] a0;
    logic [31:0] d0;
    clear_log();
    base = done_cnt;
    send(32'h1234_5A79, 8'hFF);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (avm_write) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stall_start: avm_write=0 required 1");
    end
    avm_waitrequest = 1'b1;
    a0 = avm_address;
    d0 = avm_writedata;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (avm_write !== 1'b1 || avm_address !== a0 || avm_writedata !== d0 ||
          avm_byteenable !== 4'b0001) begin
        errors++;
        $display("FAIL stall_hold%0d: write=%b addr=%h data=%h be=%b required 1/%h/%h/0001",
                 k, avm_write, avm_address, avm_writedata, avm_byteenable, a0, d0);
      end
    end
    avm_waitrequest = 1'b0;
    wait_done(base);
    checks++;
    if (wr_addr_q.size() != 1) begin
      errors++;
      $display("FAIL stall_count: writes=%0d required 1", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 32'h8 || wr_data_q[0] !== 32'hA || wr_rel_q[0] != 7) begin
        errors++;
        $display("FAIL stall_write: addr=%h data=%h cyc=%0d required addr=8 data=a cyc=7",
                 wr_addr_q[0], wr_data_q[0], wr_rel_q[0]);
      end
    end
    checks++;
    if (done_rel != 13) begin
      errors++;
      $display("FAIL stall_done: done cycle=%0d required 13", done_rel);
    end
    $display("test_stall: writes=%0d done_cycle=%0d", wr_addr_q.size(), done_rel);
  endtask

  // Fresh shadow, mask 81; a second request is held valid while busy.
  task automatic test_mask_busy();
    int base;
    int first_acc;
    bit ok;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_log();
    base = done_cnt;
    in_data  = 32'h1234_5679;
    in_mask  = 8'h81;
    in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) ok = 1;
      else @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    first_acc = acc_edge;
    in_data = 32'h8000_0005;   // must not disturb the captured request
    repeat (4) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_ready: in_ready=%b busy=%b required 0/1", in_ready, busy);
    end
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (acc_edge != first_acc) ok = 1;
      else @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (acc_edge - first_acc != 12) begin
      errors++;
      $display("FAIL busy_accept: second accept cycle=%0d required 12", acc_edge - first_acc);
    end
    wait_done(base + 1);
    checks++;
    if (wr_addr_q.size() != 4) begin
      errors++;
      $display("FAIL mask_count: writes=%0d required 4", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 32'h00 || wr_data_q[0] !== 32'h9 ||
          wr_addr_q[1] !== 32'h1C || wr_data_q[1] !== 32'h1) begin
        errors++;
        $display("FAIL mask_first: %h/%h %h/%h required 0/9 1c/1",
                 wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
      end
      checks++;
      if (wr_addr_q[2] !== 32'h00 || wr_data_q[2] !== 32'h5 ||
          wr_addr_q[3] !== 32'h1C || wr_data_q[3] !== 32'h8) begin
        errors++;
        $display("FAIL mask_second: %h/%h %h/%h required 0/5 1c/8",
                 wr_addr_q[2], wr_data_q[2], wr_addr_q[3], wr_data_q[3]);
      end
    end
    checks++;
    if (done_rel != 11) begin
      errors++;
      $display("FAIL mask_done: done cycle=%0d required 11", done_rel);
    end
    $display("test_mask_busy: writes=%0d second_accept=%0d", wr_addr_q.size(), acc_edge - first_acc);
  endtask

  // Reset while the digit-3 write is stalled, then replay the same request.
  task automatic test_reset_midwrite();
    int base;
    bit seen;
    clear_log();
    send(32'h8765_4321, 8'hFF);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (avm_write && avm_address == 32'hC) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_mid_start: digit-3 write not seen, required write to c");
    end
    avm_waitrequest = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (avm_write !== 1'b0 || busy !== 1'b0 || avm_byteenable !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_async: write=%b busy=%b be=%b required 0/0/0000",
               avm_write, busy, avm_byteenable);
    end
    @(negedge clk);
    avm_waitrequest = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_log();
    base = done_cnt;
    send(32'h8765_4321, 8'hFF);
    wait_done(base);
    checks++;
    if (wr_addr_q.size() != 8) begin
      errors++;
      $display("FAIL rst_mid_count: writes=%0d required 8", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_data_q[0] !== 32'h1 || wr_addr_q[7] !== 32'h1C || wr_data_q[7] !== 32'h8) begin
        errors++;
        $display("FAIL rst_mid_data: first=%h last=%h/%h required 1 and 1c/8",
                 wr_data_q[0], wr_addr_q[7], wr_data_q[7]);
      end
    end
    checks++;
    if (done_rel != 17) begin
      errors++;
      $display("FAIL rst_mid_done: done cycle=%0d required 17", done_rel);
    end
    $display("test_reset_midwrite: writes=%0d done_cycle=%0d", wr_addr_q.size(), done_rel);
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_no_change();
    test_single();
    test_stall();
    test_mask_busy();
    test_reset_midwrite();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
